regdst_hazard_scheduler: RTL and testbench
==========================================

Name: regdst_hazard_scheduler

Overview:
- Sequences the 5-bit destination-register select for writeback and resolves register hazards for the 5-stage CPU.
- Computes each issued instruction's destination from rt, rd or the return-address register.
- Tracks pending writes through the EX/MEM/WB tag pipeline.
- Drives the two 3-input operand forwarding mux selects, the load-use stall, and the register-file write port.

Parameters:
- ADDR_W, 5: register address width.
- RA_REG, 31: destination used when regdst_op==2 (jal).
- CNT_W, 16: width of the saturating stall counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- issue_valid  input  1  decode stage presents an instruction.
- issue_ready  output  1  instruction accepted this cycle; equals ~stall & ~flush.
- regdst_op  input  2  destination select: 0=rt, 1=rd, 2=RA_REG, 3=illegal.
- writes_reg  input  1  instruction writes the register file.
- is_load  input  1  instruction is a load; result available only at WB.
- rs, rt, rd  input  ADDR_W each  decode-stage register fields.
- uses_rs, uses_rt  input  1 each  instruction reads rs / rt.
- flush  input  1  kill the instructions in decode and EX (branch/jump redirect).
- stall  output  1  combinational load-use stall.
- fwd_a_sel, fwd_b_sel  output  2 each  EX operand select for rs / rt: 0=regfile, 1=MEM result, 2=WB result.
- wb_we  output  1  register-file write enable, registered.
- wb_dst  output  ADDR_W  register-file write address, registered.
- illegal_op  output  1  one-cycle pulse: accepted instruction had regdst_op==3.
- stall_cnt  output  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset: all stage valid bits, wb_we, illegal_op and stall_cnt are 0; wb_dst is 0. Reset overrides flush and issue. A reset mid-operation discards every in-flight tag.
- Destination computation:
  - dst = rt / rd / RA_REG for op 0/1/2.
  - Entry is marked writing when writes_reg=1 and op!=3.
  - Op 3 clears the write flag and pulses illegal_op in the cycle after acceptance.
- Stage state: EX, MEM and WB each hold {valid, wr, dst, is_load}; EX also holds rs, rt, uses_rs, uses_rt.
- Advance every cycle, no global stall:
  - WB<-MEM and MEM<-EX.
  - EX<-new entry if issue_valid & issue_ready, else bubble (valid=0).
- stall (combinational) is asserted when all of the following hold:
  - issue_valid;
  - EX.valid, EX.wr and EX.is_load;
  - EX.dst!=0;
  - (uses_rs & rs==EX.dst) | (uses_rt & rt==EX.dst).
  - Stall lasts exactly one cycle per load-use pair.
- flush:
  - That edge, MEM<-bubble (discards the EX entry) and EX<-bubble.
  - issue_ready=0 during the flush cycle.
  - WB still loads the old MEM entry.
  - Flush with stall: flush wins; stall_cnt does not increment.
- Forwarding, combinational from stage registers:
  - fwd_a_sel=1 if EX.valid & EX.uses_rs & MEM.valid & MEM.wr & MEM.dst==EX.rs & EX.rs!=0.
  - Otherwise fwd_a_sel=2 on the same match against WB.
  - Otherwise 0. MEM has priority over WB. fwd_b_sel is identical using rt.
  - Selects are 0 whenever EX.valid=0.
  - A MEM-stage load never matches: the stall guarantees the gap.
- Register-file write: wb_we = WB.valid & WB.wr & WB.dst!=0, wb_dst = WB.dst, both registered. Register 0 is never written; wb_dst keeps its last value when wb_we=0.
- Latency: instruction accepted on edge N → wb_we high in the cycle following edge N+3.
- stall_cnt increments on each edge where stall=1 and flush=0, saturating at all-ones.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with issue_valid=1 → wb_we=0, stall=0, stall_cnt=0, fwd selects 0; no writes emerge afterwards.
- Back-to-back ALU ops:
  - Stimulus: add rd=8 (op=1), then add rs=8 next cycle.
  - Response: fwd_a_sel=1 in its EX cycle, no stall; wb_we=1 with wb_dst=8 three cycles after the first acceptance.
- Load-use:
  - Stimulus: lw rt=9 (op=0, is_load), then an instruction with uses_rt=1, rt=9.
  - Response: stall=1 for exactly one cycle, issue_ready=0, then acceptance; fwd_b_sel=2 in its EX cycle; stall_cnt=1.
- jal: op=2 with writes_reg=1 → wb_dst=31 with wb_we=1; a dependent reader of $31 one cycle behind gets fwd_a_sel=1.
- Zero register, illegal op and priority:
  - Writes to rd=0 → wb_we stays 0, dependents get fwd 0.
  - op=3 → illegal_op pulses once, no write.
  - MEM and WB both targeting $5 → fwd_a_sel=1.
- Flush:
  - Assert flush while a load-use stall is active → no stall_cnt increment, EX and MEM bubbles, no later wb_we from killed entries.
  - Assert rst_n=0 mid-stream → all pending writes are dropped.

Source files
------------

// File: rtl/regdst_hazard_scheduler_if.sv
// Bundle of decode-side handshake and hazard/writeback signals for the
// regdst hazard scheduler.
//   master: decode stage / environment. Drives the issue fields and flush, and
//           receives ready, stall, forwarding selects, the writeback port,
//           illegal_op and stall_cnt.
//   slave : the scheduler. Mirror image of master.
interface regdst_hazard_scheduler_if #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic              issue_valid;
    logic              issue_ready;
    logic [1:0]        regdst_op;
    logic              writes_reg;
    logic              is_load;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] rd;
    logic              uses_rs;
    logic              uses_rt;
    logic              flush;
    logic              stall;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_dst;
    logic              illegal_op;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output issue_valid, regdst_op, writes_reg, is_load, rs, rt, rd,
               uses_rs, uses_rt, flush,
        input  issue_ready, stall, fwd_a_sel, fwd_b_sel, wb_we, wb_dst,
               illegal_op, stall_cnt
    );

    modport slave (
        input  issue_valid, regdst_op, writes_reg, is_load, rs, rt, rd,
               uses_rs, uses_rt, flush,
        output issue_ready, stall, fwd_a_sel, fwd_b_sel, wb_we, wb_dst,
               illegal_op, stall_cnt
    );
endinterface

// File: rtl/regdst_hazard_scheduler.sv
// Destination-register sequencing and hazard resolution for a 5-stage CPU.
// Each accepted instruction gets a destination tag (rt, rd or RA_REG) that
// flows EX -> MEM -> WB. The tags drive operand forwarding selects, the
// load-use stall and the registered register-file write port.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - slave side of regdst_hazard_scheduler_if (issue fields, flush,
//           ready/stall, fwd_a_sel/fwd_b_sel, wb_we/wb_dst, illegal_op,
//           stall_cnt)
module regdst_hazard_scheduler #(
    parameter int ADDR_W = 5,
    parameter int RA_REG = 31,
    parameter int CNT_W  = 16
) (
    input logic                      clk,
    input logic                      rst_n,
    regdst_hazard_scheduler_if.slave bus
);
    localparam int STAGES = 2;  // vld_pipe index: 0=EX, 1=MEM, 2=WB

    typedef struct packed {
        logic              wr;
        logic              is_load;
        logic [ADDR_W-1:0] dst;
    } tag_t;

    logic [STAGES:0]   vld_pipe;
    tag_t              ex_tag, mem_tag, wb_tag;
    logic [ADDR_W-1:0] ex_rs, ex_rt;
    logic              ex_uses_rs, ex_uses_rt;

    logic [ADDR_W-1:0] new_dst;
    logic              new_wr;
    logic              load_use, stall, accept;
    logic              wb_we, illegal_op;
    logic [ADDR_W-1:0] wb_dst;
    logic [CNT_W-1:0]  stall_cnt;

    always_comb begin
        new_dst = '0;
        case (bus.regdst_op)
            2'd0:    new_dst = bus.rt;
            2'd1:    new_dst = bus.rd;
            2'd2:    new_dst = ADDR_W'(RA_REG);
            default: new_dst = '0;
        endcase
    end
    assign new_wr = bus.writes_reg & (bus.regdst_op != 2'd3);

    // A load in EX has no result until WB, so a dependent in decode must
    // wait one cycle; after that the load sits in WB and forwards normally.
    assign load_use = vld_pipe[0] & ex_tag.wr & ex_tag.is_load & (ex_tag.dst != '0) &
                      ((bus.uses_rs & (bus.rs == ex_tag.dst)) |
                       (bus.uses_rt & (bus.rt == ex_tag.dst)));
    assign stall  = bus.issue_valid & load_use;
    assign accept = bus.issue_valid & ~stall & ~bus.flush;

    // MEM is checked first so the younger producer wins.
    function automatic logic [1:0] fwd_sel(input logic use_src, input logic [ADDR_W-1:0] src);
        if (!vld_pipe[0] || !use_src || src == '0)
            return 2'd0;
        if (vld_pipe[1] && mem_tag.wr && mem_tag.dst == src)
            return 2'd1;
        if (vld_pipe[2] && wb_tag.wr && wb_tag.dst == src)
            return 2'd2;
        return 2'd0;
    endfunction

    assign bus.stall       = stall;
    assign bus.issue_ready = ~stall & ~bus.flush;
    assign bus.fwd_a_sel   = fwd_sel(ex_uses_rs, ex_rs);
    assign bus.fwd_b_sel   = fwd_sel(ex_uses_rt, ex_rt);
    assign bus.wb_we       = wb_we;
    assign bus.wb_dst      = wb_dst;
    assign bus.illegal_op  = illegal_op;
    assign bus.stall_cnt   = stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe   <= '0;
            ex_tag     <= '0;
            mem_tag    <= '0;
            wb_tag     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_uses_rs <= 1'b0;
            ex_uses_rt <= 1'b0;
            wb_we      <= 1'b0;
            wb_dst     <= '0;
            illegal_op <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            // The pipe never freezes; flush kills the entry leaving EX.
            vld_pipe <= {vld_pipe[1], vld_pipe[0] & ~bus.flush, accept};
            wb_tag   <= mem_tag;
            mem_tag  <= ex_tag;
            if (accept) begin
                ex_tag     <= '{wr: new_wr, is_load: bus.is_load, dst: new_dst};
                ex_rs      <= bus.rs;
                ex_rt      <= bus.rt;
                ex_uses_rs <= bus.uses_rs;
                ex_uses_rt <= bus.uses_rt;
            end

            wb_we <= vld_pipe[2] & wb_tag.wr & (wb_tag.dst != '0);
            if (vld_pipe[2] && wb_tag.wr && wb_tag.dst != '0)
                wb_dst <= wb_tag.dst;

            illegal_op <= accept & (bus.regdst_op == 2'd3);

            if (stall && !bus.flush && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_regdst_hazard_scheduler.sv
module tb_regdst_hazard_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regdst_hazard_scheduler_if #(.ADDR_W(5), .CNT_W(16)) bus ();

    regdst_hazard_scheduler #(.ADDR_W(5), .RA_REG(31), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a history of what was admitted on each recent edge.
    // hist[k] is the slot admitted k+1 edges ago, so k=1 is the MEM
    // producer and k=2 the WB producer, matching the select codes.
    typedef struct {
        bit v, wr, ld, urs, urt;
        int dst, rs, rt;
    } ent_t;

    ent_t hist[$];
    bit   m_we, m_ill, m_ok;
    int   m_dst, m_cnt;

    function automatic ent_t bubble();
        ent_t e;
        e.v = 0; e.wr = 0; e.ld = 0; e.urs = 0; e.urt = 0;
        e.dst = 0; e.rs = 0; e.rt = 0;
        return e;
    endfunction

    function automatic bit m_stall();
        ent_t e = hist[0];
        if (!bus.issue_valid || !e.v || !e.wr || !e.ld || e.dst == 0) return 0;
        return (bus.uses_rs && int'(bus.rs) == e.dst) || (bus.uses_rt && int'(bus.rt) == e.dst);
    endfunction

    function automatic int m_fwd(input bit use_src, input int src);
        if (!hist[0].v || !use_src || src == 0) return 0;
        for (int k = 1; k <= 2; k++)
            if (hist[k].v && hist[k].wr && hist[k].dst == src) return k;
        return 0;
    endfunction

    always @(posedge clk) begin
        bit   st, acc;
        ent_t n;
        if (!rst_n) begin
            hist = {bubble(), bubble(), bubble()};
            m_we = 0; m_dst = 0; m_ill = 0; m_cnt = 0; m_ok = 1;
        end else if (m_ok) begin
            st  = m_stall();
            acc = bus.issue_valid && !st && !bus.flush;
            if (st && !bus.flush && m_cnt < 65535) m_cnt++;
            m_ill = acc && bus.regdst_op == 2'd3;
            if (hist[2].v && hist[2].wr && hist[2].dst != 0) begin
                m_we = 1; m_dst = hist[2].dst;
            end else begin
                m_we = 0;
            end
            if (bus.flush) hist[0].v = 0;
            n = bubble();
            n.v   = acc;
            n.wr  = bus.writes_reg && bus.regdst_op != 2'd3;
            n.ld  = bus.is_load;
            n.dst = (bus.regdst_op == 2'd0) ? int'(bus.rt) :
                    (bus.regdst_op == 2'd1) ? int'(bus.rd) : 31;
            n.rs  = int'(bus.rs);
            n.rt  = int'(bus.rt);
            n.urs = bus.uses_rs;
            n.urt = bus.uses_rt;
            hist.push_front(n);
            void'(hist.pop_back());
        end
    end

    // Compare process: every cycle once the model has seen a reset edge.
    always @(negedge clk) begin
        if (m_ok) begin
            chk("stall",       int'(bus.stall),       int'(m_stall()));
            chk("issue_ready", int'(bus.issue_ready), int'(!m_stall() && !bus.flush));
            chk("fwd_a_sel",   int'(bus.fwd_a_sel),   m_fwd(hist[0].urs, hist[0].rs));
            chk("fwd_b_sel",   int'(bus.fwd_b_sel),   m_fwd(hist[0].urt, hist[0].rt));
            chk("wb_we",       int'(bus.wb_we),       int'(m_we));
            chk("wb_dst",      int'(bus.wb_dst),      m_dst);
            chk("illegal_op",  int'(bus.illegal_op),  int'(m_ill));
            chk("stall_cnt",   int'(bus.stall_cnt),   m_cnt);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic set_ins(input bit v, input int op, input bit w, input bit ld,
                           input int rs_, input int rt_, input int rd_,
                           input bit urs, input bit urt);
        bus.issue_valid = v;
        bus.regdst_op   = 2'(op);
        bus.writes_reg  = w;
        bus.is_load     = ld;
        bus.rs          = 5'(rs_);
        bus.rt          = 5'(rt_);
        bus.rd          = 5'(rd_);
        bus.uses_rs     = urs;
        bus.uses_rt     = urt;
    endtask

    task automatic idle();
        set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        idle();
        bus.flush = 0;
        rst_n = 0;
        step();
        step();
        rst_n = 1;
    endtask

    initial begin
        bus.flush = 0;
        // Reset held two cycles with a writing instruction presented.
        rst_n = 0;
        set_ins(1, 1, 1, 0, 0, 0, 3, 0, 0);
        step();
        step();
        at_neg();
        chk("lit_reset_wb_we", int'(bus.wb_we), 0);
        chk("lit_reset_stall", int'(bus.stall), 0);
        chk("lit_reset_cnt",   int'(bus.stall_cnt), 0);
        chk("lit_reset_fwd_a", int'(bus.fwd_a_sel), 0);
        rst_n = 1;
        idle();
        step(); step(); step();
        at_neg();
        chk("lit_reset_no_write", int'(bus.wb_we), 0);

        // Back-to-back ALU: rd=8 then reader of rs=8.
        do_reset();
        set_ins(1, 1, 1, 0, 0, 0, 8, 0, 0);
        step();
        set_ins(1, 1, 1, 0, 8, 0, 10, 1, 0);
        at_neg();
        chk("lit_alu_no_stall", int'(bus.stall), 0);
        step();
        idle();
        at_neg();
        chk("lit_alu_fwd_a", int'(bus.fwd_a_sel), 1);
        step();
        step();
        at_neg();
        chk("lit_alu_wb_we",  int'(bus.wb_we), 1);
        chk("lit_alu_wb_dst", int'(bus.wb_dst), 8);

        // Load-use: lw rt=9 then reader of rt=9.
        do_reset();
        set_ins(1, 0, 1, 1, 0, 9, 0, 0, 0);
        step();
        set_ins(1, 1, 1, 0, 0, 9, 12, 0, 1);
        at_neg();
        chk("lit_lu_stall", int'(bus.stall), 1);
        chk("lit_lu_ready", int'(bus.issue_ready), 0);
        step();
        at_neg();
        chk("lit_lu_stall_once", int'(bus.stall), 0);
        chk("lit_lu_ready_back", int'(bus.issue_ready), 1);
        step();
        idle();
        at_neg();
        chk("lit_lu_fwd_b", int'(bus.fwd_b_sel), 2);
        chk("lit_lu_cnt",   int'(bus.stall_cnt), 1);

        // jal then reader of $31.
        do_reset();
        set_ins(1, 2, 1, 0, 0, 0, 0, 0, 0);
        step();
        set_ins(1, 1, 1, 0, 31, 0, 4, 1, 0);
        step();
        idle();
        at_neg();
        chk("lit_jal_fwd_a", int'(bus.fwd_a_sel), 1);
        step();
        step();
        at_neg();
        chk("lit_jal_wb_we",  int'(bus.wb_we), 1);
        chk("lit_jal_wb_dst", int'(bus.wb_dst), 31);

        // Write to $0 never writes, dependents see regfile.
        do_reset();
        set_ins(1, 1, 1, 0, 0, 0, 0, 0, 0);
        step();
        set_ins(1, 1, 0, 0, 0, 0, 0, 1, 0);
        step();
        idle();
        at_neg();
        chk("lit_zero_fwd_a", int'(bus.fwd_a_sel), 0);
        step();
        step();
        at_neg();
        chk("lit_zero_wb_we", int'(bus.wb_we), 0);

        // Illegal op: one pulse, no write.
        do_reset();
        set_ins(1, 3, 1, 0, 0, 0, 6, 0, 0);
        step();
        idle();
        at_neg();
        chk("lit_ill_pulse", int'(bus.illegal_op), 1);
        step();
        at_neg();
        chk("lit_ill_once", int'(bus.illegal_op), 0);
        step();
        step();
        at_neg();
        chk("lit_ill_no_write", int'(bus.wb_we), 0);

        // MEM and WB both write $5: MEM wins.
        do_reset();
        set_ins(1, 1, 1, 0, 0, 0, 5, 0, 0);
        step();
        step();
        set_ins(1, 1, 1, 0, 5, 0, 7, 1, 0);
        step();
        idle();
        at_neg();
        chk("lit_prio_fwd_a", int'(bus.fwd_a_sel), 1);

        // Flush during a load-use stall.
        do_reset();
        set_ins(1, 0, 1, 1, 0, 9, 0, 0, 0);
        step();
        set_ins(1, 1, 1, 0, 0, 9, 12, 0, 1);
        bus.flush = 1;
        at_neg();
        chk("lit_fl_stall", int'(bus.stall), 1);
        chk("lit_fl_ready", int'(bus.issue_ready), 0);
        step();
        bus.flush = 0;
        at_neg();
        chk("lit_fl_cnt",     int'(bus.stall_cnt), 0);
        chk("lit_fl_bubble",  int'(bus.stall), 0);
        step();
        idle();
        step();
        at_neg();
        chk("lit_fl_no_write", int'(bus.wb_we), 0);

        // Reset mid-stream drops pending writes.
        do_reset();
        set_ins(1, 1, 1, 0, 0, 0, 7, 0, 0);
        step();
        set_ins(1, 1, 1, 0, 0, 0, 6, 0, 0);
        step();
        idle();
        rst_n = 0;
        step();
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            at_neg();
            chk("lit_midrst_no_write", int'(bus.wb_we), 0);
            step();
        end

        // Randomized traffic over a small register window to force hazards.
        for (int i = 0; i < 3000; i++) begin
            set_ins($urandom_range(0, 3) != 0, $urandom_range(0, 3),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            bus.flush = $urandom_range(0, 9) == 0;
            rst_n = $urandom_range(0, 299) != 0;
            step();
        end
        rst_n = 1;
        bus.flush = 0;
        idle();
        step(); step(); step(); step();
        at_neg();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
